// File: rtl/prach_hb2_sched.sv
// Round-robin scheduler that issues one PRACH sample pair per slot from NUM_CHN channels onto a
// shared HB2 datapath, with a programmable idle gap between issues and frame-sync restart.
module prach_hb2_sched #(
  parameter int unsigned NUM_CHN = 8,
  parameter int unsigned MIN_GAP = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [NUM_CHN-1:0]      chn_mask,
  input  logic                    sync_in,
  input  logic [NUM_CHN-1:0]      req_valid,
  input  logic [NUM_CHN*64-1:0]   req_data,
  output logic [NUM_CHN-1:0]      req_ready,
  output logic [1:0][15:0]        dout_dp1,
  output logic [1:0][15:0]        dout_dp2,
  output logic                    dout_dv,
  output logic [7:0]              dout_chn,
  output logic                    sync_out,
  output logic                    busy
);

  localparam int unsigned PW = (NUM_CHN > 1) ? $clog2(NUM_CHN) : 1;
  // Counter is loaded with MIN_GAP-1 so the gap state lasts exactly MIN_GAP cycles.
  localparam logic [3:0] GapLoad = (MIN_GAP > 0) ? 4'(MIN_GAP - 1) : 4'd0;

  typedef enum logic [1:0] {StIdle, StArb, StGap} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [3:0]      gap_cnt_q, gap_cnt_d;
  logic            sync_pend_q, sync_pend_d;
  logic [1:0][15:0] dp1_q, dp1_d, dp2_q, dp2_d;
  logic            dv_q, dv_d;
  logic [7:0]      chn_q, chn_d;
  logic            sync_out_q, sync_out_d;

  logic [NUM_CHN-1:0] elig;
  logic [PW-1:0]      sel_idx;
  logic               sel_found;
  logic [PW:0]        cand;
  logic               xfer;
  logic [63:0]        chn_data [NUM_CHN];
  logic [63:0]        sel_data;

  for (genvar c = 0; c < NUM_CHN; c++) begin : g_data
    assign chn_data[c] = req_data[64*c +: 64];
  end

  assign elig = req_valid & chn_mask;

  // Priority search starting at ptr_q, wrapping past the last channel.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_CHN; i++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(i);
      if (cand >= (PW+1)'(NUM_CHN)) begin
        cand = cand - (PW+1)'(NUM_CHN);
      end
      if (!sel_found && elig[cand[PW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[PW-1:0];
      end
    end
  end

  assign xfer     = (state_q == StArb) && enable && !sync_in && sel_found;
  assign sel_data = chn_data[sel_idx];

  always_comb begin
    req_ready = '0;
    if (xfer) begin
      req_ready[sel_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gap_cnt_d   = gap_cnt_q;
    sync_pend_d = sync_pend_q;
    dp1_d       = dp1_q;
    dp2_d       = dp2_q;
    chn_d       = chn_q;
    dv_d        = xfer;
    sync_out_d  = xfer && sync_pend_q;

    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StArb;
        end
      end
      StArb: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (xfer) begin
          ptr_d = (sel_idx == PW'(NUM_CHN - 1)) ? '0 : sel_idx + PW'(1);
          if (MIN_GAP > 0) begin
            state_d   = StGap;
            gap_cnt_d = GapLoad;
          end
        end
      end
      StGap: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (gap_cnt_q == 4'd0) begin
          state_d = StArb;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (xfer) begin
      dp1_d       = sel_data[31:0];
      dp2_d       = sel_data[63:32];
      chn_d       = {{(8-PW){1'b0}}, sel_idx};
      sync_pend_d = 1'b0;
    end

    // Frame sync overrides everything; grants are already suppressed via xfer.
    if (sync_in) begin
      ptr_d       = '0;
      gap_cnt_d   = '0;
      sync_pend_d = 1'b1;
      state_d     = enable ? StArb : StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      gap_cnt_q   <= '0;
      sync_pend_q <= 1'b0;
      dp1_q       <= '0;
      dp2_q       <= '0;
      dv_q        <= 1'b0;
      chn_q       <= '0;
      sync_out_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gap_cnt_q   <= gap_cnt_d;
      sync_pend_q <= sync_pend_d;
      dp1_q       <= dp1_d;
      dp2_q       <= dp2_d;
      dv_q        <= dv_d;
      chn_q       <= chn_d;
      sync_out_q  <= sync_out_d;
    end
  end

  assign dout_dp1 = dp1_q;
  assign dout_dp2 = dp2_q;
  assign dout_dv  = dv_q;
  assign dout_chn = chn_q;
  assign sync_out = sync_out_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_prach_hb2_sched.sv
// Directed bench: one instance with MIN_GAP=1 and one with MIN_GAP=0 share the stimulus.
module tb_prach_hb2_sched;

  logic              clk;
  logic              rst_n;
  logic              enable;
  logic [7:0]        chn_mask;
  logic              sync_in;
  logic [7:0]        req_valid;
  logic [511:0]      req_data;

  logic [7:0]        req_ready, r0_ready;
  logic [1:0][15:0]  d_dp1, d_dp2, d0_dp1, d0_dp2;
  logic              d_dv, d0_dv;
  logic [7:0]        d_chn, d0_chn;
  logic              s_out, s0_out;
  logic              busy, busy0;

  int n_chk  = 0;
  int n_pass = 0;

  prach_hb2_sched #(.NUM_CHN(8), .MIN_GAP(1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .chn_mask(chn_mask), .sync_in(sync_in),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .dout_dp1(d_dp1), .dout_dp2(d_dp2), .dout_dv(d_dv), .dout_chn(d_chn),
    .sync_out(s_out), .busy(busy)
  );

  prach_hb2_sched #(.NUM_CHN(8), .MIN_GAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .chn_mask(chn_mask), .sync_in(sync_in),
    .req_valid(req_valid), .req_data(req_data), .req_ready(r0_ready),
    .dout_dp1(d0_dp1), .dout_dp2(d0_dp2), .dout_dv(d0_dv), .dout_chn(d0_chn),
    .sync_out(s0_out), .busy(busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One MIN_GAP=1 issue slot: grant in ARB, output next cycle, idle cycle after.
  task automatic issue_step(input int ch);
    logic [7:0] oh;
    oh = 8'h01 << ch;
    chk("gap1_ready", req_ready, oh);
    tick();
    chk("gap1_dv", d_dv, 1);
    chk("gap1_chn", d_chn, ch);
    chk("gap1_ready_gap", req_ready, 0);
    tick();
    chk("gap1_dv_idle", d_dv, 0);
    chk("gap1_chn_hold", d_chn, ch);
  endtask

  task automatic set_default_data();
    for (int c = 0; c < 8; c++) begin
      req_data[64*c +: 64] = {16'(c*16+4), 16'(c*16+3), 16'(c*16+2), 16'(c*16+1)};
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int seq_mask [8];
    seq_mask = '{0, 1, 2, 4, 5, 6, 7, 0};

    rst_n     = 1'b1;
    enable    = 1'b0;
    chn_mask  = 8'hFF;
    sync_in   = 1'b0;
    req_valid = 8'h00;
    set_default_data();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_dv", d_dv, 0);
    chk("rst_sync_out", s_out, 0);
    chk("rst_dp1", d_dp1, 0);
    chk("rst_dp2", d_dp2, 0);
    chk("rst_chn", d_chn, 0);
    chk("rst_busy", busy, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // Full round robin, all channels valid.
    req_valid = 8'hFF;
    enable    = 1'b1;
    #1;
    chk("idle_no_grant", req_ready, 0);
    chk("idle_busy", busy, 0);
    tick();
    chk("arb_busy", busy, 1);
    for (int k = 0; k < 9; k++) issue_step(k % 8);

    // Data path mapping for channel 4.
    req_valid = 8'h10;
    req_data[64*4 +: 64] = 64'h0004_0003_0002_0001;
    #1;
    chk("ch4_ready", req_ready, 8'h10);
    tick();
    chk("ch4_dv", d_dv, 1);
    chk("ch4_chn", d_chn, 4);
    chk("ch4_dp1", d_dp1, 32'h0002_0001);
    chk("ch4_dp2", d_dp2, 32'h0004_0003);
    tick();

    // Sync with ptr=5 restarts at channel 0.
    set_default_data();
    req_valid = 8'hFF;
    sync_in   = 1'b1;
    #1;
    chk("sync_forces_ready0", req_ready, 0);
    tick();
    sync_in = 1'b0;
    #1;
    chk("sync_no_dv", d_dv, 0);
    chk("sync_ready_ch0", req_ready, 8'h01);
    tick();
    chk("sync_issue_chn", d_chn, 0);
    chk("sync_issue_dv", d_dv, 1);
    chk("sync_out_first", s_out, 1);
    chk("sync_dp1_ch0", d_dp1, 32'h0002_0001);
    tick();
    chk("sync_out_gap", s_out, 0);
    chk("sync_ready_ch1", req_ready, 8'h02);
    tick();
    chk("sync_next_chn", d_chn, 1);
    chk("sync_out_second", s_out, 0);
    chk("sync_dp2_ch1", d_dp2, 32'h0014_0013);

    // Repeated sync before an issue gives one sync_out.
    sync_in = 1'b1;
    tick();
    #1;
    chk("resync_ready0", req_ready, 0);
    tick();
    sync_in = 1'b0;
    #1;
    chk("resync_ready_ch0", req_ready, 8'h01);
    tick();
    chk("resync_chn", d_chn, 0);
    chk("resync_sync_out", s_out, 1);
    tick();
    tick();
    chk("resync_next_dv", d_dv, 1);
    chk("resync_next_sync_out", s_out, 0);

    // Reset during the gap clears outputs immediately; restart from channel 0.
    rst_n = 1'b0;
    #1;
    chk("midgap_rst_dv", d_dv, 0);
    chk("midgap_rst_chn", d_chn, 0);
    chk("midgap_rst_dp1", d_dp1, 0);
    chk("midgap_rst_busy", busy, 0);
    chk("midgap_rst_ready", req_ready, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_idle_ready", req_ready, 0);
    tick();

    // Masked channel 3 is skipped.
    chn_mask = 8'hF7;
    #1;
    for (int k = 0; k < 8; k++) issue_step(seq_mask[k]);

    // MIN_GAP=0 instance: channels 2 and 5 alternate on consecutive cycles.
    rst_n     = 1'b0;
    chn_mask  = 8'hFF;
    req_valid = 8'h24;
    tick();
    rst_n = 1'b1;
    tick();
    chk("g0_ready_2a", r0_ready, 8'h04);
    tick();
    chk("g0_chn_2a", d0_chn, 2);
    chk("g0_dv_2a", d0_dv, 1);
    chk("g0_ready_5", r0_ready, 8'h20);
    tick();
    chk("g0_chn_5", d0_chn, 5);
    chk("g0_dv_5", d0_dv, 1);
    chk("g0_ready_2b", r0_ready, 8'h04);
    tick();
    chk("g0_chn_2b", d0_chn, 2);
    chk("g0_dv_2b", d0_dv, 1);

    // Enable drop: no new grant, idle next cycle, pointer retained.
    enable = 1'b0;
    #1;
    chk("en_off_ready", r0_ready, 0);
    chk("en_off_busy", busy0, 1);
    tick();
    chk("en_off_idle", busy0, 0);
    chk("en_off_dv", d0_dv, 0);
    enable = 1'b1;
    tick();
    chk("en_on_ptr_kept", r0_ready, 8'h20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/prach_hb2_sched.md
PRACH_HB2_SCHED -- requirements
Module: prach_hb2_sched

Interface
REQ-001 Parameter NUM_CHN, default 8: number of requesting antenna-carrier channels, range 2..16.
REQ-002 Parameter MIN_GAP, default 1: minimum idle cycles between two consecutive issues to the shared HB2 datapath, range 0..15.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 enable  input  1  run control for arbitration; 0 = no new issues.
REQ-006 chn_mask  input  NUM_CHN  per-channel enable; 0 = channel never granted.
REQ-007 sync_in  input  1  frame-boundary pulse; restarts the schedule.
REQ-008 req_valid  input  NUM_CHN  per-channel sample-pair available.
REQ-009 req_data  input  NUM_CHN*64  per channel c, bits [64c+63:64c] = {dp2_q, dp2_i, dp1_q, dp1_i}, each 16-bit signed.
REQ-010 req_ready  output  NUM_CHN  one-hot grant; transfer occurs when req_valid[c] & req_ready[c].
REQ-011 dout_dp1  output  2x16  issued phase-1 sample; [0]=I, [1]=Q.
REQ-012 dout_dp2  output  2x16  issued phase-2 sample; [0]=I, [1]=Q.
REQ-013 dout_dv  output  1  issued sample valid.
REQ-014 dout_chn  output  8  channel index of issued sample, zero-extended.
REQ-015 sync_out  output  1  marks first issue after a sync_in.
REQ-016 busy  output  1  high in S_ARB or S_GAP.

Function
REQ-017 States: S_IDLE, S_ARB, S_GAP.
REQ-018 S_IDLE -> S_ARB when enable=1; no grants in S_IDLE.
REQ-019 In S_ARB, round-robin search starts at pointer ptr and selects the first channel c (ascending, wrapping NUM_CHN-1 -> 0) with req_valid[c] & chn_mask[c].
REQ-020 req_ready[c] is asserted combinationally only for the selected channel in S_ARB; all other bits 0; no channel selected -> req_ready all 0, state stays S_ARB.
REQ-021 On transfer: ptr <= c+1, wrapping to 0 after NUM_CHN-1; state -> S_GAP if MIN_GAP>0, else stays S_ARB.
REQ-022 S_GAP holds for exactly MIN_GAP cycles with req_ready=0, then -> S_ARB; issue spacing is therefore MIN_GAP+1 cycles.
REQ-023 Outputs registered: dout_dp1/dp2/chn and dout_dv=1 appear the cycle after the transfer (latency 1); dout_dv=0 on every other cycle; data and chn hold their last value when dout_dv=0.
REQ-024 sync_in=1 in any state: ptr <= 0, gap counter cleared, req_ready forced 0 in that cycle, sync-pending flag set; state -> S_ARB if enable=1, else S_IDLE.
REQ-025 sync_out=1 together with dout_dv for the first issue after sync-pending is set; the flag then clears; sync_out=0 otherwise.
REQ-026 Repeated sync_in before any issue produces a single sync_out on the first subsequent issue.
REQ-027 enable falling to 0: in-flight output register still emits its sample; state -> S_IDLE the next cycle; ptr and sync-pending are retained.
REQ-028 chn_mask changes take effect in the next arbitration cycle; a masked channel with req_valid=1 is never granted.
REQ-029 Selection from a registered ptr plus combinational priority search; no multi-cycle paths.

Reset
REQ-030 rst_n=0 asynchronously: state=S_IDLE, ptr=0, gap counter=0, sync-pending=0, req_ready=0, dout_dv=0, sync_out=0, dout_dp1=dout_dp2=0, dout_chn=0, busy=0.
REQ-031 Reset asserted mid-gap or mid-issue discards the pending output; first grant after release requires enable=1 and follows REQ-019 from ptr=0.

Verification
REQ-032 NUM_CHN=8, MIN_GAP=1, all valid, mask=0xFF, enable=1: dout_chn sequence 0,1,...,7,0 with dout_dv on every second cycle.
REQ-033 Only channels 2 and 5 valid, MIN_GAP=0: grants alternate 2,5,2,5 on consecutive cycles; req_ready never set for any other channel.
REQ-034 sync_in while ptr=5, all valid: next issue dout_chn=0 with sync_out=1; following issue chn=1 with sync_out=0.
REQ-035 mask=0xF7, all valid: channel 3 never granted; sequence 0,1,2,4,5,6,7,0.
REQ-036 req_data for channel 4 = 0x0004_0003_0002_0001 granted: next cycle dout_dp1={1,2}, dout_dp2={3,4}, dout_chn=4, dout_dv=1.
REQ-037 rst_n pulsed low during S_GAP: all outputs 0 immediately; after release with enable=1 the first grant is channel 0.
